md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage pipelined CPU, beside the ALU.
- Consumes the EX-stage forwarded operands (the same forwarded rs/rt values the ALU receives) plus a decoded op.
- Owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU over multiple cycles, signalling busy to the hazard unit.
- Serves MTHI/MTLO writes and drives HI/LO continuously for MFHI/MFLO forwarding into the EX result path.

Parameters:
MULT_CYCLES, 5, cycles busy is held for MULT/MULTU (range 1..15)
DIV_CYCLES, 10, cycles busy is held for DIV/DIVU (range 1..15)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low (0 = reset asserted)
en  input  1  EX-stage instruction valid; 0 for bubbles and flushed slots
md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
a  input  32  forwarded rs value
b  input  32  forwarded rt value
busy  output  1  operation in flight; equals (cnt != 0)
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset while reset=0: hi=0, lo=0, cnt=0, busy=0, pending-result registers=0. Asynchronous; aborts any in-flight operation with no commit.
- Accept condition: en=1 and busy=0 at a rising edge. When en=0 or busy=1, md_op is ignored entirely, including MTHI/MTLO. The hazard unit guarantees it never issues into a busy unit; the block still drops the op.
- MULT/MULTU accepted at edge T:
  - Latch the 64-bit product (signed or unsigned) into pending {phi, plo}.
  - Load cnt=MULT_CYCLES, so busy=1 after T.
- DIV/DIVU accepted at edge T:
  - Latch pending quotient and remainder.
  - Load cnt=DIV_CYCLES.
- Each later edge with cnt>1 decrements cnt.
  - At the edge where cnt==1: hi<=phi, lo<=plo, cnt<=0, busy<=0.
  - So busy is high for exactly N cycles after T, and new HI/LO are visible from edge T+N.
  - Before that edge, hi/lo keep their old values.
- Commit mapping: MULT*: hi=product[63:32], lo=product[31:0]. DIV*: lo=quotient, hi=remainder.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the sign of the dividend (-7/2 gives q=-3, r=-1).
  - 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0.
- Divide by zero (b=0, signed or unsigned): the op is accepted and busy runs DIV_CYCLES, but hi/lo are not modified at commit.
- MTHI/MTLO accepted at edge T: hi<=a (or lo<=a) at T. No busy, visible next cycle.
- NONE/reserved: no state change.
- Operands are sampled only at the accept edge; later changes on a/b have no effect on the result.
- Back-to-back: a new op may be accepted at the same edge where busy falls only if busy was already 0 before that edge. In practice the first new accept is edge T+N+1.

Decomposition:
- Shared package: md_op encodings (MD_NONE..MD_MTLO) and the cnt width constant (4 bits). The pipeline decoder and hazard unit import the same encodings.
- One natural sub-module, md_result_calc: purely combinational, (md_op, a, b) -> {res_hi, res_lo, div_by_zero}. It holds the signed/unsigned multiply and divide so md_unit keeps only the counter, accept logic and HI/LO registers.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 at edge T -> busy=1 for 5 cycles; at T+5 hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo unchanged during T+1..T+4.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- DIV a=5, b=0 with hi=0x11, lo=0x22 preset via MTHI/MTLO -> busy 10 cycles; hi=0x11, lo=0x22 afterwards.
- While busy, drive MTLO a=0xDEAD and a second MULT, each with en=1 -> both ignored; final lo equals the first op's result. With en=0 and MTHI -> hi unchanged.
- Start DIV, pull reset low 3 cycles later -> busy=0, hi=lo=0 immediately (asynchronous); after release, MTHI a=0x1234 -> hi=0x1234 one edge later.

Source files
------------

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared md_op encodings and counter width for the multiply/divide unit
package md_unit_pkg;
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;
  localparam int CNT_W = 4;
endpackage

// File: rtl/md_result_calc.sv
// md_result_calc: combinational signed/unsigned multiply and divide producing HI/LO results
module md_result_calc
  import md_unit_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);
  logic        sgn;
  logic        is_div;
  logic [63:0] prod;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] den;
  logic [31:0] uq;
  logic [31:0] ur;
  // Divide on magnitudes then restore signs: quotient truncates toward zero and the
  // remainder follows the dividend, which also makes 0x80000000 / -1 wrap to 0x80000000.
  always_comb begin
    sgn         = (md_op == MD_MULT) || (md_op == MD_DIV);
    is_div      = (md_op == MD_DIV) || (md_op == MD_DIVU);
    prod        = {{32{sgn & a[31]}}, a} * {{32{sgn & b[31]}}, b};
    mag_a       = (sgn && a[31]) ? -a : a;
    mag_b       = (sgn && b[31]) ? -b : b;
    div_by_zero = is_div && (b == 32'd0);
    den         = (b == 32'd0) ? 32'd1 : mag_b;
    uq          = mag_a / den;
    ur          = mag_a % den;
    res_lo      = is_div ? ((sgn && (a[31] ^ b[31])) ? -uq : uq) : prod[31:0];
    res_hi      = is_div ? ((sgn && a[31]) ? -ur : ur) : prod[63:32];
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning HI/LO with a multi-cycle busy counter
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  logic [31:0]      hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [31:0]      res_hi, res_lo;
  logic             div_by_zero;
  logic             accept;

  md_result_calc u_calc (
    .md_op      (md_op),
    .a          (a),
    .b          (b),
    .res_hi     (res_hi),
    .res_lo     (res_lo),
    .div_by_zero(div_by_zero)
  );

  assign accept = en && (cnt_q == '0);
  assign busy   = cnt_q != '0;
  assign hi     = hi_q;
  assign lo     = lo_q;

  // Accept a new op when idle, otherwise count down and commit pending results on the last cycle
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    phi_d = phi_q;
    plo_d = plo_q;
    cnt_d = cnt_q;
    dz_d  = dz_q;
    if (accept) begin
      case (md_op)
        MD_MULT, MD_MULTU: begin
          phi_d = res_hi;
          plo_d = res_lo;
          dz_d  = 1'b0;
          cnt_d = CNT_W'(MULT_CYCLES);
        end
        MD_DIV, MD_DIVU: begin
          phi_d = res_hi;
          plo_d = res_lo;
          dz_d  = div_by_zero;
          cnt_d = CNT_W'(DIV_CYCLES);
        end
        MD_MTHI: hi_d = a;
        MD_MTLO: lo_d = a;
        default: ;
      endcase
    end else if (cnt_q == CNT_W'(1)) begin
      cnt_d = '0;
      hi_d  = dz_q ? hi_q : phi_q;
      lo_d  = dz_q ? lo_q : plo_q;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // State registers; asynchronous reset aborts any in-flight operation without commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      phi_q <= '0;
      plo_q <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      cnt_q <= cnt_d;
      dz_q  <= dz_d;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed stimulus with a behavioural HI/LO model and per-cycle comparison
module tb_md_unit;
  import md_unit_pkg::*;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_skip;
  int          m_cnt;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(rst_n),
    .en   (en),
    .md_op(md_op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {skip_commit, hi, lo} computed with wide integer arithmetic
  function automatic logic [64:0] model_res(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint      sp, sq, sr;
    logic [63:0] up;
    logic [63:0] tmp;
    model_res = '0;
    case (op)
      MD_MULT: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        tmp = 64'(sp);
        model_res = {1'b0, tmp[63:32], tmp[31:0]};
      end
      MD_MULTU: begin
        up = {32'd0, x} * {32'd0, y};
        model_res = {1'b0, up[63:32], up[31:0]};
      end
      MD_DIV: begin
        if (y == 0) model_res = {1'b1, 64'd0};
        else begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          model_res = {1'b0, 32'(sr), 32'(sq)};
        end
      end
      MD_DIVU: model_res = (y == 0) ? {1'b1, 64'd0} : {1'b0, x % y, x / y};
      default: ;
    endcase
  endfunction

  // Behavioural model: busy for N cycles after accept, then commit unless divide by zero
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= 0; m_lo <= 0; m_phi <= 0; m_plo <= 0; m_skip <= 0; m_cnt <= 0;
    end else if (m_cnt == 0) begin
      if (en) begin
        if (md_op == MD_MULT || md_op == MD_MULTU || md_op == MD_DIV || md_op == MD_DIVU) begin
          {m_skip, m_phi, m_plo} <= model_res(md_op, a, b);
          m_cnt <= (md_op == MD_MULT || md_op == MD_MULTU) ? MC : DC;
        end
        if (md_op == MD_MTHI) m_hi <= a;
        if (md_op == MD_MTLO) m_lo <= a;
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !m_skip) begin
        m_hi <= m_phi;
        m_lo <= m_plo;
      end
    end
  end

  // Compare every cycle outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(m_cnt != 0));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    en = 1'b1; md_op = op; a = x; b = y;
    @(negedge clk);
    en = 1'b0; md_op = MD_NONE; a = 32'hA5A5A5A5; b = 32'h5A5A5A5A;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic expect_hl(input string name, input logic [31:0] eh, input logic [31:0] el);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
    chk({name, "_model_hi"}, m_hi, eh);
    chk({name, "_model_lo"}, m_lo, el);
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; md_op = MD_NONE; a = 0; b = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    expect_hl("rst", 32'd0, 32'd0);
    rst_n = 1'b1;

    issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
    for (int i = 0; i < MC; i++) begin
      chk("mult_busy", 32'(busy), 32'd1);
      chk("mult_hold_hi", hi, 32'd0);
      chk("mult_hold_lo", lo, 32'd0);
      @(negedge clk);
    end
    chk("mult_done", 32'(busy), 32'd0);
    expect_hl("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle();
    expect_hl("multu", 32'hFFFFFFFE, 32'h00000001);

    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    for (int i = 0; i < DC; i++) begin
      chk("div_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    chk("div_done", 32'(busy), 32'd0);
    expect_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

    issue(MD_DIVU, 32'hFFFFFFF9, 32'd2);
    wait_idle();
    expect_hl("divu", 32'h00000001, 32'h7FFFFFFC);

    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    expect_hl("div_ovf", 32'h00000000, 32'h80000000);

    issue(MD_MTHI, 32'h11, 32'd0);
    chk("mthi", hi, 32'h11);
    issue(MD_MTLO, 32'h22, 32'd0);
    chk("mtlo", lo, 32'h22);
    issue(MD_DIV, 32'd5, 32'd0);
    chk("dz_busy", 32'(busy), 32'd1);
    wait_idle();
    expect_hl("div0", 32'h11, 32'h22);

    issue(MD_MULT, 32'd7, 32'd6);
    issue(MD_MTLO, 32'hDEAD, 32'd0);
    issue(MD_MULT, 32'd3, 32'd3);
    wait_idle();
    expect_hl("busy_ignore", 32'h0, 32'h2A);

    md_op = MD_MTHI; a = 32'h999; en = 1'b0;
    @(negedge clk);
    md_op = MD_NONE;
    chk("en0_mthi", hi, 32'h0);

    issue(MD_MTHI, 32'h55, 32'd0);
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(MD_MTHI, 32'h1234, 32'd0);
    chk("post_rst_mthi", hi, 32'h1234);
    repeat (12) @(negedge clk);
    chk("post_rst_lo", lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
